// File: rtl/ace_snoop_resp_driver.sv
// ace_snoop_resp_driver
// Converts the level-style outputs of the snoop-response FSM into ACE CR and CD
// channel transfers. A CR response is one handshake. A CD response is a full
// cache-line burst of BEATS beats, and the last beat carries CDLAST. The block
// reports when both channels are idle, counts completed transfers and keeps
// sticky error flags that only reset clears.
module ace_snoop_resp_driver #(
    parameter int C_ACE_DATA_WIDTH   = 128,
    parameter int C_CACHE_LINE_BYTES = 64
) (
    input  logic                        ace_aclk,
    input  logic                        ace_aresetn,
    input  logic                        i_crvalid,
    input  logic [4:0]                  i_crresp,
    input  logic                        i_cdvalid,
    input  logic                        i_cdlast,
    input  logic [C_ACE_DATA_WIDTH-1:0] i_rdata,
    output logic                        o_up_ready,
    output logic                        o_crvalid,
    output logic [4:0]                  o_crresp,
    input  logic                        i_crready,
    output logic                        o_cdvalid,
    output logic [C_ACE_DATA_WIDTH-1:0] o_cddata,
    output logic                        o_cdlast,
    input  logic                        i_cdready,
    output logic [31:0]                 o_cr_count,
    output logic [31:0]                 o_cd_count,
    output logic                        o_err_overrun,
    output logic                        o_err_unexp
);

    localparam int BEATS = (C_CACHE_LINE_BYTES * 8) / C_ACE_DATA_WIDTH;
    localparam int BCW   = $clog2(BEATS) + 1;
    // Index of the beat whose handshake ends the non-last part of the burst.
    localparam logic [BCW-1:0] LAST_BODY_IDX = (BEATS > 1) ? BCW'(BEATS - 2) : '0;

    typedef enum logic {
        CR_IDLE,
        CR_SEND
    } cr_state_e;

    typedef enum logic [1:0] {
        CD_IDLE,
        CD_BEAT,
        CD_WAIT_LAST,
        CD_LAST
    } cd_state_e;

    cr_state_e                   cr_state_q;
    cd_state_e                   cd_state_q;
    logic                        crvalid_prev_q;
    logic                        cdvalid_prev_q;
    logic                        cdlast_prev_q;
    logic                        crvalid_q;
    logic [4:0]                  crresp_q;
    logic                        cdvalid_q;
    logic                        cdlast_q;
    logic [C_ACE_DATA_WIDTH-1:0] cddata_q;
    logic [BCW-1:0]              beat_cnt_q;
    logic                        last_seen_q;
    logic                        last_seen_d;
    logic [31:0]                 cr_count_q;
    logic [31:0]                 cd_count_q;
    logic                        err_overrun_q;
    logic                        err_unexp_q;

    logic cr_rise;
    logic cd_rise;
    logic cdlast_rise;
    logic cd_last_hs;
    logic resp_bit0;

    assign cr_rise     = i_crvalid & ~crvalid_prev_q;
    assign cd_rise     = i_cdvalid & ~cdvalid_prev_q;
    assign cdlast_rise = i_cdlast & ~cdlast_prev_q;
    assign cd_last_hs  = (cd_state_q == CD_LAST) & i_cdready;

    // A CR response being latched this cycle is the one that governs a CD burst
    // starting in the same cycle. Otherwise the last latched response applies.
    assign resp_bit0 = (cr_rise && cr_state_q == CR_IDLE) ? i_crresp[0] : crresp_q[0];

    // A clearing handshake drops only the old line's marker. A cdlast rise in the
    // same cycle belongs to the next line and survives.
    assign last_seen_d = (last_seen_q & ~cd_last_hs) | cdlast_rise;

    // Previous-value registers for rising-edge detection, plus the last_seen marker.
    // NOTE: these reset to 0, so an input held high across reset release is seen
    // as a fresh rise. Upstream must drop its levels during reset.
    always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
        if (!ace_aresetn) begin
            crvalid_prev_q <= 1'b0;
            cdvalid_prev_q <= 1'b0;
            cdlast_prev_q  <= 1'b0;
            last_seen_q    <= 1'b0;
        end else begin
            crvalid_prev_q <= i_crvalid;
            cdvalid_prev_q <= i_cdvalid;
            cdlast_prev_q  <= i_cdlast;
            last_seen_q    <= last_seen_d;
        end
    end

    // CR channel FSM: one handshake per crvalid rise, with a registered payload.
    always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
        if (!ace_aresetn) begin
            cr_state_q <= CR_IDLE;
            crvalid_q  <= 1'b0;
            crresp_q   <= '0;
            cr_count_q <= '0;
        end else begin
            case (cr_state_q)
                CR_IDLE: begin
                    if (cr_rise) begin
                        cr_state_q <= CR_SEND;
                        crvalid_q  <= 1'b1;
                        crresp_q   <= i_crresp;
                    end
                end
                CR_SEND: begin
                    if (i_crready) begin
                        cr_state_q <= CR_IDLE;
                        crvalid_q  <= 1'b0;
                        cr_count_q <= cr_count_q + 32'd1;
                    end
                end
                default: begin
                    cr_state_q <= CR_IDLE;
                    crvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    // CD channel FSM: a burst of BEATS beats. The final beat is held back until
    // cdlast has been seen, so that a late cdlast becomes a stall rather than a
    // change of payload while valid is asserted.
    always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
        if (!ace_aresetn) begin
            cd_state_q <= CD_IDLE;
            cdvalid_q  <= 1'b0;
            cdlast_q   <= 1'b0;
            cddata_q   <= '0;
            beat_cnt_q <= '0;
            cd_count_q <= '0;
        end else begin
            case (cd_state_q)
                CD_IDLE: begin
                    if (cd_rise) begin
                        cddata_q   <= i_rdata;
                        beat_cnt_q <= '0;
                        if (BEATS > 1) begin
                            cd_state_q <= CD_BEAT;
                            cdvalid_q  <= 1'b1;
                        end else begin
                            cd_state_q <= CD_WAIT_LAST;
                        end
                    end
                end
                CD_BEAT: begin
                    if (i_cdready) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (beat_cnt_q == LAST_BODY_IDX) begin
                            cd_state_q <= CD_WAIT_LAST;
                            cdvalid_q  <= 1'b0;
                        end
                    end
                end
                CD_WAIT_LAST: begin
                    if (last_seen_q) begin
                        cd_state_q <= CD_LAST;
                        cdvalid_q  <= 1'b1;
                        cdlast_q   <= 1'b1;
                    end
                end
                CD_LAST: begin
                    if (i_cdready) begin
                        cd_state_q <= CD_IDLE;
                        cdvalid_q  <= 1'b0;
                        cdlast_q   <= 1'b0;
                        cd_count_q <= cd_count_q + 32'd1;
                    end
                end
                default: begin
                    cd_state_q <= CD_IDLE;
                    cdvalid_q  <= 1'b0;
                    cdlast_q   <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flags. Only reset clears them.
    always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
        if (!ace_aresetn) begin
            err_overrun_q <= 1'b0;
            err_unexp_q   <= 1'b0;
        end else begin
            if ((cr_rise && cr_state_q != CR_IDLE) || (cd_rise && cd_state_q != CD_IDLE)) begin
                err_overrun_q <= 1'b1;
            end
            if (cd_rise && cd_state_q == CD_IDLE && !resp_bit0) begin
                err_unexp_q <= 1'b1;
            end
        end
    end

    assign o_up_ready    = (cr_state_q == CR_IDLE) && (cd_state_q == CD_IDLE);
    assign o_crvalid     = crvalid_q;
    assign o_crresp      = crresp_q;
    assign o_cdvalid     = cdvalid_q;
    assign o_cddata      = cddata_q;
    assign o_cdlast      = cdlast_q;
    assign o_cr_count    = cr_count_q;
    assign o_cd_count    = cd_count_q;
    assign o_err_overrun = err_overrun_q;
    assign o_err_unexp   = err_unexp_q;

endmodule

// File: tb/tb_ace_snoop_resp_driver.sv
// Directed testbench for ace_snoop_resp_driver with the default configuration
// (128-bit data, 64-byte line, 4 beats). Inputs change 1 ns after the rising
// edge, and outputs are sampled at that same point.
module tb_ace_snoop_resp_driver;

    localparam int DW = 128;

    logic          ace_aclk;
    logic          ace_aresetn;
    logic          i_crvalid;
    logic [4:0]    i_crresp;
    logic          i_cdvalid;
    logic          i_cdlast;
    logic [DW-1:0] i_rdata;
    logic          o_up_ready;
    logic          o_crvalid;
    logic [4:0]    o_crresp;
    logic          i_crready;
    logic          o_cdvalid;
    logic [DW-1:0] o_cddata;
    logic          o_cdlast;
    logic          i_cdready;
    logic [31:0]   o_cr_count;
    logic [31:0]   o_cd_count;
    logic          o_err_overrun;
    logic          o_err_unexp;

    int n_vec = 0;
    int n_err = 0;

    ace_snoop_resp_driver #(
        .C_ACE_DATA_WIDTH  (DW),
        .C_CACHE_LINE_BYTES(64)
    ) dut (
        .ace_aclk     (ace_aclk),
        .ace_aresetn  (ace_aresetn),
        .i_crvalid    (i_crvalid),
        .i_crresp     (i_crresp),
        .i_cdvalid    (i_cdvalid),
        .i_cdlast     (i_cdlast),
        .i_rdata      (i_rdata),
        .o_up_ready   (o_up_ready),
        .o_crvalid    (o_crvalid),
        .o_crresp     (o_crresp),
        .i_crready    (i_crready),
        .o_cdvalid    (o_cdvalid),
        .o_cddata     (o_cddata),
        .o_cdlast     (o_cdlast),
        .i_cdready    (i_cdready),
        .o_cr_count   (o_cr_count),
        .o_cd_count   (o_cd_count),
        .o_err_overrun(o_err_overrun),
        .o_err_unexp  (o_err_unexp)
    );

    initial ace_aclk = 1'b0;
    always #5 ace_aclk = ~ace_aclk;

    task automatic tick();
        @(posedge ace_aclk);
        #1;
    endtask

    task automatic idle_inputs();
        i_crvalid = 1'b0;
        i_cdvalid = 1'b0;
        i_cdlast  = 1'b0;
        tick();
        tick();
    endtask

    // Runs for the given number of cycles with the ready inputs held and counts
    // CD handshakes, beats flagged last, the beat number that carried last, and
    // beats whose data differs from exp.
    task automatic run_cd(input int cycles, input logic [DW-1:0] exp,
                          output int hs, output int lasts, output int last_at,
                          output int bad_data);
        hs = 0; lasts = 0; last_at = 0; bad_data = 0;
        for (int c = 0; c < cycles; c++) begin
            if (o_cdvalid && i_cdready) begin
                hs++;
                if (o_cdlast) begin
                    lasts++;
                    last_at = hs;
                end
                if (o_cddata !== exp) bad_data++;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        ace_aresetn = 1'b0;
        i_crvalid = 0; i_crresp = 0; i_cdvalid = 0; i_cdlast = 0;
        i_rdata = '0; i_crready = 0; i_cdready = 0;
        #3;
        n_vec++;
        if ({o_crvalid, o_crresp, o_cdvalid, o_cddata, o_cdlast, o_cr_count, o_cd_count,
             o_err_overrun, o_err_unexp} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got crv=%b resp=%h cdv=%b last=%b crc=%0d cdc=%0d ov=%b ux=%b, want all 0",
                     o_crvalid, o_crresp, o_cdvalid, o_cdlast, o_cr_count, o_cd_count,
                     o_err_overrun, o_err_unexp);
        end
        tick();
        tick();
        ace_aresetn = 1'b1;
        tick();
        n_vec++;
        if (o_up_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_up_ready: got %b want 1", o_up_ready);
        end
    endtask

    task automatic test_cr_single();
        i_crvalid = 1; i_crresp = 5'b00001; i_crready = 1;
        n_vec++;
        if (o_crvalid !== 1'b0) begin
            n_err++;
            $display("FAIL cr_pre_valid: got %b want 0", o_crvalid);
        end
        tick();
        n_vec++;
        if (o_crvalid !== 1'b1 || o_crresp !== 5'd1 || o_up_ready !== 1'b0) begin
            n_err++;
            $display("FAIL cr_send: got valid=%b resp=%h up=%b want 1/01/0", o_crvalid, o_crresp, o_up_ready);
        end
        tick();
        n_vec++;
        if (o_crvalid !== 1'b0 || o_cr_count !== 32'd1 || o_up_ready !== 1'b1) begin
            n_err++;
            $display("FAIL cr_done: got valid=%b count=%0d up=%b want 0/1/1", o_crvalid, o_cr_count, o_up_ready);
        end
        idle_inputs();
    endtask

    task automatic test_cr_cd_together();
        int hs, lasts, last_at, bad;
        i_crvalid = 1; i_crresp = 5'b00001; i_crready = 1;
        i_cdvalid = 1; i_cdlast = 1; i_rdata = 128'h11; i_cdready = 1;
        tick();
        n_vec++;
        if (o_crvalid !== 1'b1 || o_cdvalid !== 1'b1 || o_cdlast !== 1'b0) begin
            n_err++;
            $display("FAIL both_start: got crv=%b cdv=%b last=%b want 1/1/0", o_crvalid, o_cdvalid, o_cdlast);
        end
        run_cd(20, 128'h11, hs, lasts, last_at, bad);
        n_vec++;
        if (hs !== 4 || lasts !== 1 || last_at !== 4 || bad !== 0) begin
            n_err++;
            $display("FAIL burst4: got hs=%0d lasts=%0d last_at=%0d bad=%0d want 4/1/4/0", hs, lasts, last_at, bad);
        end
        n_vec++;
        if (o_cd_count !== 32'd1 || o_cr_count !== 32'd2 || o_up_ready !== 1'b1 || o_err_unexp !== 1'b0) begin
            n_err++;
            $display("FAIL burst4_counts: got cd=%0d cr=%0d up=%b ux=%b want 1/2/1/0",
                     o_cd_count, o_cr_count, o_up_ready, o_err_unexp);
        end
        idle_inputs();
    endtask

    task automatic test_delayed_last();
        int hs, lasts, last_at, bad;
        i_cdvalid = 1; i_cdlast = 0; i_rdata = 128'h33; i_cdready = 1;
        tick();
        run_cd(150, 128'h33, hs, lasts, last_at, bad);
        n_vec++;
        if (hs !== 3 || lasts !== 0 || bad !== 0 || o_cdvalid !== 1'b0) begin
            n_err++;
            $display("FAIL delay_body: got hs=%0d lasts=%0d bad=%0d cdv=%b want 3/0/0/0", hs, lasts, bad, o_cdvalid);
        end
        i_cdlast = 1;
        run_cd(10, 128'h33, hs, lasts, last_at, bad);
        n_vec++;
        if (hs !== 1 || lasts !== 1 || bad !== 0 || o_cd_count !== 32'd2) begin
            n_err++;
            $display("FAIL delay_last: got hs=%0d lasts=%0d bad=%0d count=%0d want 1/1/0/2", hs, lasts, bad, o_cd_count);
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        int hs = 0;
        int held_bad = 0;
        logic          pv = 0, pr = 0, pl = 0;
        logic [DW-1:0] pd = '0;
        i_cdvalid = 1; i_cdlast = 1; i_rdata = 128'h22; i_cdready = 0;
        tick();
        for (int c = 0; c < 40; c++) begin
            i_rdata   = {4{$urandom()}};
            i_cdready = c[0];
            if (pv && !pr) begin
                n_vec++;
                if (o_cdvalid !== 1'b1 || o_cddata !== pd || o_cdlast !== pl) begin
                    n_err++;
                    held_bad++;
                    $display("FAIL bp_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b", o_cdvalid, o_cddata, o_cdlast, pd, pl);
                end
            end
            if (o_cdvalid) begin
                n_vec++;
                if (o_cddata !== 128'h22) begin
                    n_err++;
                    $display("FAIL bp_data: got %h want 22", o_cddata);
                end
                if (i_cdready) hs++;
            end
            pv = o_cdvalid; pr = i_cdready; pd = o_cddata; pl = o_cdlast;
            tick();
        end
        n_vec++;
        if (hs !== 4 || o_cd_count !== 32'd3 || o_err_overrun !== 1'b0 || o_err_unexp !== 1'b0) begin
            n_err++;
            $display("FAIL bp_count: got hs=%0d count=%0d ov=%b ux=%b want 4/3/0/0", hs, o_cd_count, o_err_overrun, o_err_unexp);
        end
        i_cdready = 1;
        idle_inputs();
    endtask

    task automatic test_cr_overrun();
        int hs = 0;
        i_crready = 0; i_crvalid = 1; i_crresp = 5'b00001;
        tick();
        i_crvalid = 0;
        tick();
        i_crvalid = 1;
        tick();
        n_vec++;
        if (o_err_overrun !== 1'b1 || o_crvalid !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_flag: got ov=%b crv=%b want 1/1", o_err_overrun, o_crvalid);
        end
        i_crvalid = 0; i_crready = 1;
        for (int c = 0; c < 6; c++) begin
            if (o_crvalid && i_crready) hs++;
            tick();
        end
        n_vec++;
        if (hs !== 1 || o_cr_count !== 32'd3 || o_err_overrun !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_hs: got hs=%0d count=%0d ov=%b want 1/3/1", hs, o_cr_count, o_err_overrun);
        end
        idle_inputs();
    endtask

    task automatic test_unexpected();
        int hs, lasts, last_at, bad;
        i_crvalid = 1; i_crresp = 5'b00000; i_crready = 1;
        i_cdvalid = 1; i_cdlast = 1; i_rdata = 128'h44; i_cdready = 1;
        tick();
        n_vec++;
        if (o_err_unexp !== 1'b1) begin
            n_err++;
            $display("FAIL unexp_flag: got %b want 1", o_err_unexp);
        end
        run_cd(12, 128'h44, hs, lasts, last_at, bad);
        n_vec++;
        if (hs !== 4 || o_cd_count !== 32'd4 || o_cr_count !== 32'd4 || o_err_unexp !== 1'b1) begin
            n_err++;
            $display("FAIL unexp_done: got hs=%0d cd=%0d cr=%0d ux=%b want 4/4/4/1", hs, o_cd_count, o_cr_count, o_err_unexp);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_burst();
        int hs = 0;
        int h2, lasts, last_at, bad;
        i_cdvalid = 1; i_cdlast = 0; i_rdata = 128'h55; i_cdready = 1;
        tick();
        for (int c = 0; c < 10 && hs < 2; c++) begin
            if (o_cdvalid && i_cdready) hs++;
            tick();
        end
        n_vec++;
        if (hs !== 2 || o_cdvalid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_setup: got hs=%0d cdv=%b want 2/1", hs, o_cdvalid);
        end
        #2;
        ace_aresetn = 1'b0;
        #1;
        n_vec++;
        if ({o_crvalid, o_crresp, o_cdvalid, o_cddata, o_cdlast, o_cr_count, o_cd_count,
             o_err_overrun, o_err_unexp} !== '0) begin
            n_err++;
            $display("FAIL mid_reset: got cdv=%b last=%b data=%h crc=%0d cdc=%0d ov=%b ux=%b want all 0",
                     o_cdvalid, o_cdlast, o_cddata, o_cr_count, o_cd_count, o_err_overrun, o_err_unexp);
        end
        i_cdvalid = 0; i_cdlast = 0; i_crvalid = 0;
        tick();
        tick();
        #2;
        ace_aresetn = 1'b1;
        tick();
        run_cd(10, 128'h55, h2, lasts, last_at, bad);
        n_vec++;
        if (h2 !== 0 || o_up_ready !== 1'b1 || o_cr_count !== 32'd0 || o_cd_count !== 32'd0) begin
            n_err++;
            $display("FAIL post_reset_quiet: got hs=%0d up=%b cr=%0d cd=%0d want 0/1/0/0", h2, o_up_ready, o_cr_count, o_cd_count);
        end
        i_crvalid = 1; i_crresp = 5'b00001; i_crready = 1;
        i_cdvalid = 1; i_cdlast = 1; i_rdata = 128'h66;
        tick();
        run_cd(12, 128'h66, h2, lasts, last_at, bad);
        n_vec++;
        if (h2 !== 4 || last_at !== 4 || bad !== 0 || o_cd_count !== 32'd1 || o_cr_count !== 32'd1 || o_err_unexp !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_burst: got hs=%0d last_at=%0d bad=%0d cd=%0d cr=%0d ux=%b want 4/4/0/1/1/0",
                     h2, last_at, bad, o_cd_count, o_cr_count, o_err_unexp);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_cr_single();
        test_cr_cd_together();
        test_delayed_last();
        test_backpressure();
        test_cr_overrun();
        test_unexpected();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
